// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the multiply scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding and the worst-case iteration count of the radix-4 multiply unit.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Radix-4 iterations needed for the widest 32-bit multiplier magnitude (2^31).
  localparam int MULT_MAX_ITER = 16;

endpackage

// File: rtl/mult_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot pick among req, searching upward from ptr with wrap.
// Latency: purely combinational.
// Backpressure: none; en=0 forces an empty grant.
// Ports: req (N requests), ptr (highest-priority index, must be < N), en (allow a grant),
//        grant (one-hot or zero), grant_idx (binary index of grant, 0 when empty).
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic          found;
  logic [PW:0]   cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      // ptr + i wrapped into 0..N-1 without a divider; one spare bit holds the sum.
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(N)) begin
        cand = cand - (PW+1)'(N);
      end
      if (en && !found && req[cand[PW-1:0]]) begin
        found                  = 1'b1;
        grant[cand[PW-1:0]]    = 1'b1;
        grant_idx              = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one iterative radix-4 multiply unit between NREQ requesters.
// Latency: accept at T, mult_begin from T+1, mult_end expected at T+2+k, resp_valid at T+3+k.
// Backpressure: response held stable while resp_ready=0; no grants issued until it drains.
// Ports: clk/resetn; req_valid/req_op1/req_op2 in, req_ready out (one-hot grant);
//        resp_valid/resp_id/resp_product out, resp_ready in;
//        mult_begin/mult_op1/mult_op2 out to the multiply unit, mult_end/product back from it.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*32-1:0]  req_op1,
  input  logic [NREQ*32-1:0]  req_op2,
  output logic [NREQ-1:0]     req_ready,
  output logic                resp_valid,
  output logic [IDW-1:0]      resp_id,
  output logic [63:0]         resp_product,
  input  logic                resp_ready,
  output logic                mult_begin,
  output logic [31:0]         mult_op1,
  output logic [31:0]         mult_op2,
  input  logic                mult_end,
  input  logic [63:0]         product
);

  localparam int PW = $clog2(NREQ);

  state_e          state;
  state_e          next_state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cur_id;
  logic [NREQ-1:0] grant;
  logic            armed;
  logic            busy_first;
  logic            accept;
  logic            end_seen;
  logic [31:0]     win_op1;
  logic [31:0]     win_op2;

  // armed keeps req_ready low until the first clock edge after reset release, so a
  // requester already waiting cannot see a grant in the same cycle resetn rises.
  rr_arbiter #(.N(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        ((state == IDLE) && armed),
    .grant     (grant),
    .grant_idx (win_idx)
  );

  assign req_ready  = grant;
  assign accept     = |grant;
  assign resp_valid = (state == RESP);

  // The first BUSY cycle may still carry the previous operation's mult_end (the
  // multiply unit needs a cycle to see mult_begin), so it is ignored there.
  assign end_seen = (state == BUSY) && !busy_first && mult_end;

  always_comb begin
    win_op1 = '0;
    win_op2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == PW'(i)) begin
        win_op1 = req_op1[i*32 +: 32];
        win_op2 = req_op2[i*32 +: 32];
      end
    end
  end

  always_comb begin
    resp_id          = '0;
    resp_id[PW-1:0]  = cur_id;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)     next_state = BUSY;
      BUSY:    if (end_seen)   next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      cur_id       <= '0;
      armed        <= 1'b0;
      busy_first   <= 1'b0;
      mult_begin   <= 1'b0;
      mult_op1     <= '0;
      mult_op2     <= '0;
      resp_product <= '0;
    end else begin
      state      <= next_state;
      armed      <= 1'b1;
      // Registered so it drops on the same edge that consumes mult_end; the
      // multiply unit therefore never sees a second rising mult_begin.
      mult_begin <= (next_state == BUSY);

      if (accept) begin
        mult_op1   <= win_op1;
        mult_op2   <= win_op2;
        cur_id     <= win_idx;
        rr_ptr     <= (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
        busy_first <= 1'b1;
      end else if (state == BUSY) begin
        busy_first <= 1'b0;
      end

      if (end_seen) begin
        resp_product <= product;
      end
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched with a behavioural multiply unit and a transaction model.
// Latency: n/a.
// Backpressure: resp_ready driven by directed phases and randomly.
module tb_mult_sched;
  import mult_sched_pkg::*;

  logic         clk = 1'b0;
  logic         resetn;
  logic [3:0]   req_valid;
  logic [127:0] req_op1;
  logic [127:0] req_op2;
  logic [3:0]   req_ready;
  logic         resp_valid;
  logic [2:0]   resp_id;
  logic [63:0]  resp_product;
  logic         resp_ready;
  logic         mult_begin;
  logic [31:0]  mult_op1;
  logic [31:0]  mult_op2;
  logic         mult_end;
  logic [63:0]  product = '0;

  mult_sched #(.NREQ(4), .IDW(3)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .resp_ready   (resp_ready),
    .mult_begin   (mult_begin),
    .mult_op1     (mult_op1),
    .mult_op2     (mult_op2),
    .mult_end     (mult_end),
    .product      (product)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- helpers ----------------
  function automatic int kof(input logic [31:0] v);
    logic [32:0] mag;
    int bl;
    mag = v[31] ? (33'd0 - {1'b1, v}) : {1'b0, v};
    bl = 0;
    for (int i = 0; i < 33; i++) if (mag[i]) bl = i + 1;
    return (bl + 1) / 2;
  endfunction

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  function automatic logic [3:0] pick(input logic [3:0] v, input int p);
    for (int i = 0; i < 4; i++) begin
      if (v[(p + i) % 4]) return 4'b0001 << ((p + i) % 4);
    end
    return 4'b0000;
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- model / environment state ----------------
  int          cyc = 0;
  int          m_phase = 0;   // 0 idle, 1 multiplying, 2 response pending
  int          m_cnt = 0;     // cycles since accept while multiplying
  int          m_k = 0;
  int          m_ptr = 0;
  int          m_id = 0;
  logic        m_armed = 1'b0;
  logic [31:0] m_op1 = '0, m_op2 = '0;
  logic [63:0] m_prod = '0;

  int          mm_cnt = 0;
  int          mm_k = 0;
  logic [63:0] mm_prod = '0;
  logic        mm_end = 1'b0;
  logic        inj_end = 1'b0;
  logic        force_inj = 1'b0;
  logic        rnd_inj = 1'b0;
  assign mult_end = mm_end | inj_end;

  logic [3:0]  exp_ready;
  logic        prev_rv = 1'b0, prev_mb = 1'b0;
  int          dut_acc_cycle = 0, hs_cycle = 0, last_lat = 0, resp_cnt = 0;
  logic [63:0] last_prod = '0;
  logic [2:0]  last_id = '0;
  logic [31:0] last_mop1 = '0, last_mop2 = '0;
  logic [3:0]  last_acc_vec = '0;
  int          grant_log[$];

  always @(negedge clk) begin
    int idx;
    cyc++;
    // compare DUT against the transaction model for this cycle
    exp_ready = (resetn && m_phase == 0 && m_armed) ? pick(req_valid, m_ptr) : 4'b0;
    chk("req_ready", req_ready, exp_ready);
    chk("mult_begin", mult_begin, resetn && m_phase == 1);
    chk("resp_valid", resp_valid, resetn && m_phase == 2);
    if (!resetn) begin
      chk("rst_resp_id", resp_id, 0);
      chk("rst_resp_product", resp_product, 0);
      chk("rst_mult_op1", mult_op1, 0);
      chk("rst_mult_op2", mult_op2, 0);
    end else if (m_phase == 1) begin
      chk("mult_op1", mult_op1, m_op1);
      chk("mult_op2", mult_op2, m_op2);
    end else if (m_phase == 2) begin
      chk("resp_id", resp_id, m_id);
      chk("resp_product", resp_product, m_prod);
    end

    // observations used by directed literal checks and stimulus
    last_acc_vec = req_ready & req_valid;
    if (|last_acc_vec) begin
      dut_acc_cycle = cyc;
      grant_log.push_back(onehot_idx(req_ready));
    end
    if (mult_begin && !prev_mb) begin
      last_mop1 = mult_op1;
      last_mop2 = mult_op2;
    end
    if (resp_valid && !prev_rv) begin
      resp_cnt++;
      last_lat  = cyc - dut_acc_cycle;
      last_prod = resp_product;
      last_id   = resp_id;
    end
    if (resp_valid && resp_ready) hs_cycle = cyc;
    prev_rv = resp_valid;
    prev_mb = mult_begin;

    // spurious mult_end where it must be ignored: outside the operation or its first cycle
    inj_end = force_inj | (rnd_inj && resetn && (m_phase != 1 || m_cnt == 1) &&
                           ($urandom_range(0, 7) == 0));

    // advance the transaction model across the coming edge
    if (!resetn) begin
      m_phase = 0; m_ptr = 0; m_cnt = 0; m_armed = 1'b0;
    end else begin
      case (m_phase)
        0: if (exp_ready != 4'b0) begin
          idx     = onehot_idx(exp_ready);
          m_id    = idx;
          m_op1   = req_op1[idx*32 +: 32];
          m_op2   = req_op2[idx*32 +: 32];
          m_prod  = smul(m_op1, m_op2);
          m_k     = kof(m_op2);
          m_ptr   = (idx + 1) % 4;
          m_phase = 1;
          m_cnt   = 1;
        end
        1: if (m_cnt == 2 + m_k) m_phase = 2; else m_cnt++;
        2: if (resp_ready) m_phase = 0;
        default: m_phase = 0;
      endcase
      m_armed = 1'b1;
    end

    // behavioural multiply unit (no reset): done after k radix-4 steps
    if (mult_begin) begin
      if (mm_cnt == 0) begin
        mm_k    = kof(mult_op2);
        mm_prod = smul(mult_op1, mult_op2);
      end
      mm_cnt++;
      mm_end = (mm_cnt == 2 + mm_k);
    end else begin
      mm_cnt = 0;
      mm_end = 1'b0;
    end
    product = mm_prod;
  end

  // ---------------- stimulus ----------------
  localparam int TMO = 4 * MULT_MAX_ITER;

  task automatic set_req(input int r, input logic v, input logic [31:0] a, input logic [31:0] b);
    req_valid[r]        = v;
    req_op1[r*32 +: 32] = a;
    req_op2[r*32 +: 32] = b;
  endtask

  task automatic wait_grant(input int r, input string nm);
    logic got;
    got = 1'b0;
    for (int i = 0; i < TMO && !got; i++) begin
      @(negedge clk); #1;
      got = req_ready[r];
    end
    chk(nm, got, 1);
  endtask

  task automatic wait_resp(input int n0, input string nm);
    for (int i = 0; i < TMO && resp_cnt == n0; i++) begin
      @(negedge clk); #1;
    end
    chk(nm, resp_cnt != n0, 1);
  endtask

  task automatic run_one(input int r, input logic [31:0] a, input logic [31:0] b);
    int n0;
    n0 = resp_cnt;
    @(posedge clk); #1;
    set_req(r, 1'b1, a, b);
    wait_grant(r, "grant_timeout");
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    wait_resp(n0, "resp_timeout");
  endtask

  int n0;
  int fexp[5] = '{0, 1, 2, 3, 0};

  initial begin
    resetn     = 1'b0;
    resp_ready = 1'b1;
    req_valid  = '0;
    req_op1    = '0;
    req_op2    = '0;
    for (int r = 0; r < 4; r++) set_req(r, 1'b1, 32'(r + 1), 32'(r + 2));

    // reset state, with every requester already waiting
    #12;
    chk("reset_req_ready", req_ready, 0);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp_id", resp_id, 0);
    chk("reset_resp_product", resp_product, 0);
    chk("reset_mult_begin", mult_begin, 0);
    chk("reset_mult_op1", mult_op1, 0);
    chk("reset_mult_op2", mult_op2, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    #1 chk("no_grant_at_release", req_ready, 0);

    // fairness: all four held high
    for (int i = 0; i < 300 && grant_log.size() < 5; i++) begin
      @(negedge clk); #1;
    end
    chk("fair_grant_count", grant_log.size() >= 5, 1);
    @(posedge clk); #1;
    req_valid = '0;
    for (int i = 0; i < 5; i++)
      chk("fair_grant_order", (i < grant_log.size()) ? grant_log[i] : -1, fexp[i]);
    for (int i = 0; i < 300 && resp_cnt < 5; i++) begin
      @(negedge clk); #1;
    end
    chk("fair_resp_count", resp_cnt, 5);

    // single request and sign/width corners
    run_one(0, 32'd3, 32'd5);
    chk("p3x5_product", last_prod, 64'd15);
    chk("p3x5_id", last_id, 0);
    chk("p3x5_latency", last_lat, 5);
    chk("p3x5_mult_op1", last_mop1, 32'd3);
    chk("p3x5_mult_op2", last_mop2, 32'd5);

    run_one(2, -32'sd7, 32'd6);
    chk("neg7x6_product", last_prod, 64'hFFFF_FFFF_FFFF_FFD6);
    chk("neg7x6_id", last_id, 2);

    run_one(1, 32'h8000_0000, 32'h8000_0000);
    chk("min_sq_product", last_prod, 64'h4000_0000_0000_0000);
    chk("min_sq_latency", last_lat, 19);

    run_one(3, 32'd1234, 32'd0);
    chk("op2_zero_product", last_prod, 64'd0);
    chk("op2_zero_latency", last_lat, 3);

    run_one(0, 32'd0, 32'hFFFF_FFFF);
    chk("op1_zero_product", last_prod, 64'd0);
    chk("op1_zero_latency", last_lat, 4);

    // backpressure: response held for 10 cycles while requester 0 waits
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n0 = resp_cnt;
    set_req(3, 1'b1, 32'd100, -32'sd3);
    wait_grant(3, "bp_grant_timeout");
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    set_req(0, 1'b1, 32'd7, 32'd7);
    wait_resp(n0, "bp_resp_timeout");
    repeat (10) @(negedge clk);
    #1;
    chk("bp_hold_product", resp_product, 64'hFFFF_FFFF_FFFF_FED4);
    chk("bp_hold_id", resp_id, 3);
    chk("bp_hold_valid", resp_valid, 1);
    chk("bp_no_req_ready", req_ready, 0);
    chk("bp_mult_begin_low", mult_begin, 0);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    n0 = resp_cnt;
    wait_grant(0, "bp_next_grant_timeout");
    chk("bp_next_grant_gap", dut_acc_cycle - hs_cycle, 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_resp(n0, "bp_next_resp_timeout");
    chk("bp_next_product", last_prod, 64'd49);

    // reset in the middle of a long operation
    n0 = resp_cnt;
    @(posedge clk); #1;
    set_req(1, 1'b1, 32'h8000_0000, 32'h8000_0000);
    wait_grant(1, "rst_grant_timeout");
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b0;
    set_req(2, 1'b1, -32'sd7, 32'd6);
    #1;
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_resp_id", resp_id, 0);
    chk("midrst_resp_product", resp_product, 0);
    chk("midrst_mult_begin", mult_begin, 0);
    chk("midrst_mult_op1", mult_op1, 0);
    chk("midrst_mult_op2", mult_op2, 0);
    @(posedge clk); #1;
    resetn    = 1'b1;
    force_inj = 1'b1;
    #1 chk("midrst_no_grant_at_release", req_ready, 0);
    @(posedge clk); #1;
    force_inj = 1'b0;
    wait_grant(2, "postrst_grant_timeout");
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    wait_resp(n0, "postrst_resp_timeout");
    chk("postrst_product", last_prod, 64'hFFFF_FFFF_FFFF_FFD6);
    chk("postrst_id", last_id, 2);
    chk("postrst_latency", last_lat, 5);
    chk("postrst_single_resp", resp_cnt, n0 + 1);

    // randomized traffic, backpressure and spurious mult_end
    n0 = resp_cnt;
    rnd_inj = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int r = 0; r < 4; r++) begin
        if (last_acc_vec[r]) begin
          if ($urandom_range(0, 1) == 0) req_valid[r] = 1'b0;
          else set_req(r, 1'b1, rand_op(), rand_op());
        end else if (!req_valid[r]) begin
          if ($urandom_range(0, 2) == 0) set_req(r, 1'b1, rand_op(), rand_op());
        end else if ($urandom_range(0, 29) == 0) begin
          req_valid[r] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req_valid  = '0;
    rnd_inj    = 1'b0;
    resp_ready = 1'b1;
    repeat (30) @(negedge clk);
    chk("random_progress", resp_cnt > n0 + 50, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
